// File: rtl/icache_line_fill.sv
// Instruction-cache refill engine: fetches one full line word by word from memory,
// writes each word into the data array, then commits the tag/valid entry.
module icache_line_fill #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int INDEX_WIDTH = 5,
    parameter int BLOCK_WIDTH = 2
) (
    input  logic                                          i_clock,
    input  logic                                          i_reset,
    input  logic                                          i_req,
    input  logic [ADDR_WIDTH-1:0]                         i_addr,
    output logic                                          o_busy,
    output logic                                          o_done,
    output logic                                          o_mem_rd,
    output logic [ADDR_WIDTH-1:0]                         o_mem_addr,
    input  logic                                          i_mem_ack,
    input  logic [DATA_WIDTH-1:0]                         i_mem_rdata,
    output logic [INDEX_WIDTH-1:0]                        o_index,
    output logic [BLOCK_WIDTH-1:0]                        o_block,
    output logic [DATA_WIDTH-1:0]                         o_data,
    output logic                                          o_wr,
    output logic [ADDR_WIDTH-INDEX_WIDTH-BLOCK_WIDTH-3:0] o_tag,
    output logic                                          o_tag_wr
);

    localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - BLOCK_WIDTH - 2;
    localparam int TAG_LSB   = INDEX_WIDTH + BLOCK_WIDTH + 2;
    localparam int INDEX_LSB = BLOCK_WIDTH + 2;
    localparam logic [BLOCK_WIDTH-1:0] LAST_BLOCK = '1;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WRITE,
        COMMIT
    } state_t;

    state_t                 state_reg, state_next;
    logic [TAG_WIDTH-1:0]   tag_reg, tag_next;
    logic [INDEX_WIDTH-1:0] index_reg, index_next;
    logic [BLOCK_WIDTH-1:0] block_reg, block_next;
    logic [DATA_WIDTH-1:0]  data_reg, data_next;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_reg <= IDLE;
            tag_reg   <= '0;
            index_reg <= '0;
            block_reg <= '0;
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            tag_reg   <= tag_next;
            index_reg <= index_next;
            block_reg <= block_next;
            data_reg  <= data_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        tag_next   = tag_reg;
        index_next = index_reg;
        block_next = block_reg;
        data_next  = data_reg;
        case (state_reg)
            IDLE: begin
                // Fills always start at block 0; the block bits of the miss address are ignored.
                if (i_req) begin
                    tag_next   = i_addr[ADDR_WIDTH-1:TAG_LSB];
                    index_next = i_addr[TAG_LSB-1:INDEX_LSB];
                    block_next = '0;
                    state_next = FETCH;
                end
            end
            FETCH: begin
                if (i_mem_ack) begin
                    data_next  = i_mem_rdata;
                    state_next = WRITE;
                end
            end
            WRITE: begin
                if (block_reg == LAST_BLOCK) begin
                    state_next = COMMIT;
                end else begin
                    block_next = block_reg + BLOCK_WIDTH'(1);
                    state_next = FETCH;
                end
            end
            COMMIT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // All outputs decode from registered state only, so no input reaches an output combinationally.
    assign o_busy     = (state_reg != IDLE);
    assign o_mem_rd   = (state_reg == FETCH);
    assign o_wr       = (state_reg == WRITE);
    assign o_tag_wr   = (state_reg == COMMIT);
    assign o_done     = (state_reg == COMMIT);
    assign o_mem_addr = {tag_reg, index_reg, block_reg, 2'b00};
    assign o_index    = index_reg;
    assign o_block    = block_reg;
    assign o_data     = data_reg;
    assign o_tag      = tag_reg;

endmodule

// File: doc/icache_line_fill.md
Name: icache_line_fill

Overview:
- Memory-side refill engine for the instruction cache: the writer end of the cache fill interface.
- On a miss, accepts a line request and fetches 2**BLOCK_WIDTH words from main memory over a valid/ack bus.
- Writes each word into the cache data array at (index, block), then commits the tag/valid entry for the line.
- Sits between the cache controller miss path and the instruction memory bus.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, word width; one word per block.
- INDEX_WIDTH, 5, cache index width in bits.
- BLOCK_WIDTH, 2, block-in-line width in bits.
- Derived (localparam): TAG_WIDTH = ADDR_WIDTH-INDEX_WIDTH-BLOCK_WIDTH-2.

Ports:
- i_clock  in  1  clock.
- i_reset  in  1  synchronous active-high reset.
- i_req  in  1  fill request, sampled in IDLE only.
- i_addr  in  ADDR_WIDTH  miss address; fields are tag [ADDR-1:IDX+BLK+2], index [IDX+BLK+1:BLK+2], block/byte ignored.
- o_busy  out  1  high whenever state != IDLE.
- o_done  out  1  one-cycle pulse when the line is committed.
- o_mem_rd  out  1  memory read request.
- o_mem_addr  out  ADDR_WIDTH  word address {tag,index,block,2'b00}.
- i_mem_ack  in  1  read data valid, one cycle.
- i_mem_rdata  in  DATA_WIDTH  read data.
- o_index  out  INDEX_WIDTH  cache line being filled.
- o_block  out  BLOCK_WIDTH  block being written.
- o_data  out  DATA_WIDTH  data to cache array.
- o_wr  out  1  data array write strobe.
- o_tag  out  TAG_WIDTH  tag to commit.
- o_tag_wr  out  1  tag/valid write strobe.

Behaviour:
- Reset is i_reset, synchronous, active-high; the clock is i_clock.
- Reset forces state=IDLE, block=0, data reg=0, tag/index regs=0.
- After reset, all strobes (o_mem_rd, o_wr, o_tag_wr, o_done) are 0 and o_busy=0.
- Outputs are Moore: decoded from state and registers only. There is no combinational path from i_mem_ack or i_req to any output.
- IDLE:
  - When i_req=1, latch tag and index from i_addr and set block=0, then go to FETCH.
  - i_req is ignored in every other state; no queuing.
- FETCH:
  - o_mem_rd=1; o_mem_addr holds stable until ack.
  - When i_mem_ack=1, capture i_mem_rdata into the data register and go to WRITE.
  - Otherwise stay in FETCH indefinitely; there is no timeout.
- WRITE:
  - o_wr=1 for exactly one cycle, with o_index/o_block/o_data driven from registers.
  - If block==2**BLOCK_WIDTH-1, go to COMMIT.
  - Otherwise block=block+1 (width-wrapped) and go to FETCH.
- COMMIT:
  - o_tag_wr=1 and o_done=1 for one cycle, then go to IDLE.
  - Only COMMIT sets the line valid.
- The fill is always line-aligned and in ascending order from block 0; the block bits of i_addr are ignored.
- i_mem_ack outside FETCH is ignored; it is neither captured nor counted.
- Latency with zero-wait memory (ack in the first FETCH cycle):
  - Accept edge, then COMMIT occurs 2*2**BLOCK_WIDTH+1 cycles later.
  - With the defaults, o_done is high in cycle 9 after accept.
  - Each memory wait cycle adds one cycle.
- o_busy rises the cycle after i_req is accepted and falls the cycle after COMMIT. The cache controller may issue a new request the cycle o_busy=0.
- Reset mid-fill:
  - Return to IDLE immediately, with no further o_wr and no o_tag_wr. The partial line stays invalid.
  - A late i_mem_ack after reset is ignored.
- Outputs o_index/o_tag/o_block/o_data remain at their last register values in IDLE. They are qualified only by the strobes.

Test Plan:
- Reset check: hold i_reset 2 cycles with i_req=1 and i_mem_ack=1 → o_busy, o_mem_rd, o_wr, o_tag_wr and o_done stay 0, and state is IDLE after release.
- Zero-wait fill, i_addr=0x0000_1234:
  - o_mem_addr sequence is 0x1230, 0x1234, 0x1238, 0x123C.
  - o_wr pulses with o_index=3 and o_block=0..3, carrying the data 0xA0..0xA3 returned by memory.
  - o_tag_wr with o_tag=0x9, and o_done in cycle 9 after accept.
- Wait states: ack delayed 3 cycles on each word → o_mem_rd and o_mem_addr stay stable while waiting, o_done arrives in cycle 21, and exactly 4 o_wr pulses occur.
- Request while busy: pulse i_req with a different address during a fill → ignored; the current line completes unchanged, and there is no second fill.
- Spurious ack: assert i_mem_ack in IDLE and in WRITE → no capture, no extra o_wr, and the block counter is unchanged.
- Reset mid-fill: assert i_reset after the 2nd o_wr → no o_tag_wr and no o_done. A following request for 0x0000_0040 fills index 4 from block 0 correctly.
